// File: rtl/vec_best_match.sv
// vec_best_match: consumes the VecMatch distance stream, tracks the minimum
// distance and its library index per image vector, emits one result record
// per image vector with a norm-relative hit flag, and flags the end of a run.

`ifndef CFG_IMG_VEC_NUM
`define CFG_IMG_VEC_NUM 2
`endif
`ifndef CFG_LIB_VEC_NUM
`define CFG_LIB_VEC_NUM 4
`endif
`ifndef CFG_VEC_WIDTH
`define CFG_VEC_WIDTH 16
`endif

module vec_best_match #(
    parameter int IMG_VEC_N = `CFG_IMG_VEC_NUM,
    parameter int LIB_VEC_N = `CFG_LIB_VEC_NUM,
    parameter int VEC_WIDTH = `CFG_VEC_WIDTH,
    parameter int THR_NUM   = 1,
    parameter int THR_SHIFT = 2,
    localparam int DIST_W   = $clog2(VEC_WIDTH + 1),
    localparam int IMG_IW   = (IMG_VEC_N > 1) ? $clog2(IMG_VEC_N) : 1,
    localparam int LIB_IW   = (LIB_VEC_N > 1) ? $clog2(LIB_VEC_N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIST_W-1:0] in_data,
    input  logic [DIST_W-1:0] in_norm,
    input  logic              in_inner_done,
    input  logic              in_outer_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IMG_IW-1:0] res_img_idx,
    output logic [LIB_IW-1:0] res_lib_idx,
    output logic [DIST_W-1:0] res_dist,
    output logic              res_hit,
    output logic              all_done,
    output logic              err
);

    // Hit compare width: DIST_W plus room for up to 8 bits of shift or an
    // 8-bit numerator, so neither side can wrap.
    localparam int HW = DIST_W + 8;
    localparam logic [IMG_IW-1:0] IMG_LAST = IMG_IW'(IMG_VEC_N - 1);
    localparam logic [LIB_IW-1:0] LIB_LAST = LIB_IW'(LIB_VEC_N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [IMG_IW-1:0] img_cnt_q;
    logic [LIB_IW-1:0] lib_cnt_q;
    logic [DIST_W-1:0] best_dist_q;
    logic [LIB_IW-1:0] best_idx_q;
    logic              last_img_q;
    logic              in_ready_q;
    logic              res_valid_q;
    logic [IMG_IW-1:0] res_img_idx_q;
    logic [LIB_IW-1:0] res_lib_idx_q;
    logic [DIST_W-1:0] res_dist_q;
    logic              res_hit_q;
    logic              all_done_q;
    logic              err_q;

    logic              beat;
    logic              take;
    logic              lib_last;
    logic              img_last;
    logic              end_d;
    logic              err_d;
    logic [DIST_W-1:0] best_dist_d;
    logic [LIB_IW-1:0] best_idx_d;
    logic [HW-1:0]     hit_lhs;
    logic [HW-1:0]     hit_rhs;
    logic              hit_d;

    // Running-minimum update, end/error detection and hit compare for the current beat.
    always_comb begin
        beat        = in_valid & in_ready_q;
        lib_last    = (lib_cnt_q == LIB_LAST);
        img_last    = (img_cnt_q == IMG_LAST);
        take        = (lib_cnt_q == '0) | (in_data < best_dist_q);
        best_dist_d = take ? in_data   : best_dist_q;
        best_idx_d  = take ? lib_cnt_q : best_idx_q;
        end_d       = in_inner_done | in_outer_done | lib_last;
        // Forced end, early end, misplaced outer end, outer end without inner end.
        err_d       = (lib_last & ~in_inner_done)
                    | (in_inner_done & ~lib_last)
                    | (in_outer_done & ~img_last)
                    | (in_outer_done & ~in_inner_done);
        hit_lhs     = HW'(best_dist_d) << THR_SHIFT;
        hit_rhs     = HW'(in_norm) * HW'(THR_NUM);
        hit_d       = (hit_lhs <= hit_rhs);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            img_cnt_q     <= '0;
            lib_cnt_q     <= '0;
            best_dist_q   <= '0;
            best_idx_q    <= '0;
            last_img_q    <= 1'b0;
            in_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_img_idx_q <= '0;
            res_lib_idx_q <= '0;
            res_dist_q    <= '0;
            res_hit_q     <= 1'b0;
            all_done_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_ACCUM;
                        in_ready_q <= 1'b1;
                        img_cnt_q  <= '0;
                        lib_cnt_q  <= '0;
                        last_img_q <= 1'b0;
                        err_q      <= 1'b0;
                        all_done_q <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (beat) begin
                        best_dist_q <= best_dist_d;
                        best_idx_q  <= best_idx_d;
                        lib_cnt_q   <= lib_cnt_q + 1'b1;
                        if (err_d) begin
                            err_q <= 1'b1;
                        end
                        if (end_d) begin
                            state_q       <= S_EMIT;
                            in_ready_q    <= 1'b0;
                            res_valid_q   <= 1'b1;
                            res_img_idx_q <= img_cnt_q;
                            res_lib_idx_q <= best_idx_d;
                            res_dist_q    <= best_dist_d;
                            res_hit_q     <= hit_d;
                            last_img_q    <= in_outer_done | img_last;
                        end
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        lib_cnt_q   <= '0;
                        if (last_img_q) begin
                            state_q    <= S_DONE;
                            all_done_q <= 1'b1;
                        end else begin
                            state_q    <= S_ACCUM;
                            in_ready_q <= 1'b1;
                            img_cnt_q  <= img_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign res_valid   = res_valid_q;
    assign res_img_idx = res_img_idx_q;
    assign res_lib_idx = res_lib_idx_q;
    assign res_dist    = res_dist_q;
    assign res_hit     = res_hit_q;
    assign all_done    = all_done_q;
    assign err         = err_q;

endmodule
